riscv_mc_ctrl: RTL and testbench

Multicycle sequencing controller for the RV32I core. It turns the single-cycle controller into a Moore main FSM plus combinational ALU and immediate decoders, so one shared ALU and one unified instruction/data memory port serve each instruction over several cycles. It sits beside the multicycle datapath and drives its register enables and mux selects. It also stalls on a simple memory ready handshake.

---
 rtl/riscv_mc_pkg.sv | 49 ++++
 rtl/riscv_mc_aludec.sv | 30 +++
 rtl/riscv_mc_ctrl.sv | 156 +++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the RV32I multicycle controller: FSM states, opcodes
// and the select/function encodings driven into the datapath.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic op_legal(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
             (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// Combinational ALU decoder: maps ALUOp and the funct fields to ALUControl.
module riscv_mc_aludec
   import riscv_mc_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] ALUControl
);

   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) distinguishes sub; addi ignores Instr[30]
               3'b000:  ALUControl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I sequencing controller: Moore main FSM with MemReady-qualified
// strobes, plus immediate-format and ALU decoding for the shared datapath.
module riscv_mc_ctrl
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   state_t     state, state_nxt;
   logic       mem_req, mem_write, ir_write, pc_update, branch, reg_write, illegal;
   logic [1:0] alu_op;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    if (MemReady) state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_R:         state_nxt = EXECR;
               OP_I:         state_nxt = EXECI;
               OP_BEQ:       state_nxt = BEQ;
               OP_JAL:       state_nxt = JAL;
               default:      state_nxt = FETCH;
            endcase
         end
         MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (MemReady) state_nxt = MEMWB;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: if (MemReady) state_nxt = FETCH;
         EXECR:    state_nxt = ALUWB;
         EXECI:    state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         BEQ:      state_nxt = FETCH;
         JAL:      state_nxt = ALUWB;
         default:  state_nxt = FETCH;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ResultSrc = RES_ALUOUT;
      alu_op    = ALUOP_ADD;
      case (state)
         FETCH: begin
            mem_req   = 1'b1;
            ir_write  = MemReady;
            pc_update = MemReady;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            illegal = !op_legal(op);
         end
         MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            AdrSrc    = 1'b1;
            mem_write = MemReady;
         end
         EXECR: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
         end
         EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         ALUWB:    reg_write = 1'b1;
         BEQ: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are gated by reset so an asynchronous abort never leaks a write
   assign MemReq   = mem_req & reset;
   assign MemWrite = mem_write & reset;
   assign IRWrite  = ir_write & reset;
   assign PCWrite  = (pc_update | (branch & Zero)) & reset;
   assign RegWrite = reg_write & reset;
   assign Illegal  = illegal & reset;

   always_comb begin
      case (op)
         OP_LW, OP_I: ImmSrc = IMM_I;
         OP_SW:       ImmSrc = IMM_S;
         OP_BEQ:      ImmSrc = IMM_B;
         OP_JAL:      ImmSrc = IMM_J;
         default:     ImmSrc = IMM_I;
      endcase
   end

   riscv_mc_aludec u_aludec (
      .ALUOp      (alu_op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .ALUControl (ALUControl)
   );

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and compared on the falling edge.
module tb_riscv_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, MemReady;
   logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ImmSrc, ALUControl;

   logic [6:0] i_op;
   logic [2:0] i_f3;
   logic       i_f7;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string       tag;
      logic [18:0] v;
   } exp_t;
   exp_t sbq[$];

   logic [18:0] obs;
   assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal};

   riscv_mc_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%b exp=%b (t=%0t)", tag, got, exp, $time);
   endtask

   // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,A,B,Res,Imm,ALUCtl,Illegal}
   function automatic logic [18:0] ev(input logic mr, input logic mw, input logic ad,
                                      input logic ir, input logic pw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic [2:0] im,
                                      input logic [2:0] ac, input logic il);
      return {mr, mw, ad, ir, pw, rw, a, b, rs, im, ac, il};
   endfunction

   function automatic logic [18:0] fe(input logic r, input logic [2:0] im);
      return ev(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b10, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] de(input logic [2:0] im, input logic il);
      return ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, im, 3'b000, il);
   endfunction
   function automatic logic [18:0] madr(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] mrd(input logic [2:0] im);
      return ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] mwb(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] mwr(input logic r, input logic [2:0] im);
      return ev(1, r, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] exr(input logic [2:0] ac);
      return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, ac, 0);
   endfunction
   function automatic logic [18:0] exi(input logic [2:0] ac);
      return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, ac, 0);
   endfunction
   function automatic logic [18:0] awb(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
   endfunction
   function automatic logic [18:0] beqv(input logic z);
      return ev(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 3'b010, 3'b001, 0);
   endfunction
   function automatic logic [18:0] rstv(input logic [2:0] im);
      return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, im, 3'b000, 0);
   endfunction

   // One clock cycle: apply inputs just after the edge and queue the expected outputs
   task automatic cyc(input logic rdy, input logic z, input logic [18:0] e, input string tag);
      @(posedge clk);
      #1;
      op = i_op; funct3 = i_f3; funct7b5 = i_f7; MemReady = rdy; Zero = z;
      sbq.push_back('{tag: tag, v: e});
   endtask

   task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [2:0] ac, input string nm);
      i_op = o; i_f3 = f3; i_f7 = f7;
      cyc(1, 0, fe(1, 3'b000), {nm, ".F"});
      cyc(0, 0, de(3'b000, 0), {nm, ".D"});
      cyc(0, 1, (o == 7'b0110011) ? exr(ac) : exi(ac), {nm, ".EX"});
      cyc(1, 0, awb(3'b000), {nm, ".WB"});
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check(e.tag, obs, e.v);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout n_chk=%0d", n_chk);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
      i_op = 7'b0; i_f3 = 3'b0; i_f7 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", obs, rstv(3'b000));
      @(posedge clk);
      #1;
      reset = 1'b1;

      alu_instr(7'b0110011, 3'b000, 1'b0, 3'b000, "add");
      alu_instr(7'b0110011, 3'b000, 1'b1, 3'b001, "sub");
      alu_instr(7'b0010011, 3'b000, 1'b1, 3'b000, "addi_f7");
      alu_instr(7'b0110011, 3'b010, 1'b0, 3'b101, "slt");
      alu_instr(7'b0010011, 3'b110, 1'b0, 3'b011, "ori");
      alu_instr(7'b0110011, 3'b111, 1'b0, 3'b010, "and");
      alu_instr(7'b0110011, 3'b001, 1'b0, 3'b000, "sll_add");

      // lw: MemReady low for two MEMREAD cycles, seven cycles total
      i_op = 7'b0000011; i_f3 = 3'b010; i_f7 = 1'b0;
      cyc(1, 0, fe(1, 3'b000), "lw.F");
      cyc(0, 0, de(3'b000, 0), "lw.D");
      cyc(0, 0, madr(3'b000), "lw.MA");
      cyc(0, 0, mrd(3'b000), "lw.MR0");
      cyc(0, 0, mrd(3'b000), "lw.MR1");
      cyc(1, 0, mrd(3'b000), "lw.MR2");
      cyc(0, 0, mwb(3'b000), "lw.WB");

      // sw with a fetch stall and a store stall
      i_op = 7'b0100011;
      cyc(0, 0, fe(0, 3'b001), "sw.F0");
      cyc(1, 0, fe(1, 3'b001), "sw.F1");
      cyc(1, 0, de(3'b001, 0), "sw.D");
      cyc(1, 0, madr(3'b001), "sw.MA");
      cyc(0, 0, mwr(0, 3'b001), "sw.MW0");
      cyc(1, 0, mwr(1, 3'b001), "sw.MW1");

      i_op = 7'b1100011;
      cyc(1, 1, fe(1, 3'b010), "beqt.F");
      cyc(1, 1, de(3'b010, 0), "beqt.D");
      cyc(1, 1, beqv(1), "beqt.BEQ");
      cyc(1, 0, fe(1, 3'b010), "beqn.F");
      cyc(1, 0, de(3'b010, 0), "beqn.D");
      cyc(1, 0, beqv(0), "beqn.BEQ");

      i_op = 7'b1101111;
      cyc(1, 0, fe(1, 3'b011), "jal.F");
      cyc(1, 0, de(3'b011, 0), "jal.D");
      cyc(1, 0, ev(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b011, 3'b000, 0), "jal.JAL");
      cyc(1, 0, awb(3'b011), "jal.WB");

      // Illegal opcode: one-cycle pulse, then straight back to FETCH
      i_op = 7'b1111111;
      cyc(1, 0, fe(1, 3'b000), "ill.F");
      cyc(1, 0, de(3'b000, 1), "ill.D");
      cyc(1, 0, fe(1, 3'b000), "ill.F2");
      cyc(1, 0, de(3'b000, 1), "ill.D2");

      // Asynchronous reset in the middle of a store
      i_op = 7'b0100011;
      cyc(1, 0, fe(1, 3'b001), "rst.F");
      cyc(1, 0, de(3'b001, 0), "rst.D");
      cyc(1, 0, madr(3'b001), "rst.MA");
      @(posedge clk);
      #1;
      MemReady = 1'b1;
      #1;
      check("rst.mw_before", obs, mwr(1, 3'b001));
      reset = 1'b0;
      #1;
      check("rst.async", obs, rstv(3'b001));
      @(posedge clk);
      #1;
      check("rst.hold", obs, rstv(3'b001));

      i_op = 7'b0110011; i_f3 = 3'b000; i_f7 = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1; op = i_op; funct3 = i_f3; funct7b5 = i_f7; MemReady = 1'b1;
      sbq.push_back('{tag: "rst.F", v: fe(1, 3'b000)});
      cyc(1, 0, de(3'b000, 0), "rst.D2");
      cyc(1, 0, exr(3'b000), "rst.EX");
      cyc(1, 0, awb(3'b000), "rst.WB");

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      check("drain", 19'(sbq.size()), 19'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
